// File: rtl/icache_linefill_ctrl.sv
// icache_linefill_ctrl: single-outstanding instruction-cache line refill sequencer
module icache_linefill_ctrl #(
    parameter int MSHR_ENTRY_INDEX_WIDTH = 3,
    parameter int ICACHE_INDEX_WIDTH     = 5,
    parameter int ADDR_WIDTH             = 32,
    parameter int BEAT_WIDTH             = 64,
    parameter int LINE_BEATS             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              txreq_vld,
    output logic                              txreq_rdy,
    input  logic [ADDR_WIDTH-1:0]             txreq_addr,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     txreq_set,
    input  logic                              txreq_way,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] txreq_id,
    output logic                              mem_req_vld,
    input  logic                              mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] mem_req_id,
    input  logic                              mem_rsp_vld,
    output logic                              mem_rsp_rdy,
    input  logic [BEAT_WIDTH-1:0]             mem_rsp_data,
    input  logic                              mem_rsp_last,
    output logic                              dataram_wr_vld,
    input  logic                              dataram_wr_rdy,
    output logic                              dataram_wr_way,
    output logic [ICACHE_INDEX_WIDTH-1:0]     dataram_wr_set,
    output logic [$clog2(LINE_BEATS)-1:0]     dataram_wr_beat,
    output logic [BEAT_WIDTH-1:0]             dataram_wr_data,
    output logic                              linefill_done,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_ack_index,
    output logic                              rsp_err
);
    localparam int BW = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t                            state;
    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [ICACHE_INDEX_WIDTH-1:0]     set_q;
    logic                              way_q;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] id_q;
    logic [BW-1:0]                     beat_q;
    logic                              beat_acc;
    logic                              final_beat;

    // Handshake outputs decode straight from the state register; rst masks them so
    // nothing is offered while reset is held, even once the state is already IDLE.
    assign txreq_rdy      = !rst && state == IDLE;
    assign mem_req_vld    = !rst && state == REQ;
    assign mem_rsp_rdy    = !rst && state == DATA && dataram_wr_rdy;
    assign dataram_wr_vld = !rst && state == DATA && mem_rsp_vld;
    assign linefill_done  = !rst && state == DONE;

    assign mem_req_addr       = mem_req_vld ? addr_q : '0;
    assign mem_req_id         = mem_req_vld ? id_q : '0;
    assign dataram_wr_way     = dataram_wr_vld ? way_q : 1'b0;
    assign dataram_wr_set     = dataram_wr_vld ? set_q : '0;
    assign dataram_wr_beat    = dataram_wr_vld ? beat_q : '0;
    assign dataram_wr_data    = dataram_wr_vld ? mem_rsp_data : '0;
    assign linefill_ack_index = linefill_done ? id_q : '0;

    assign beat_acc   = dataram_wr_vld && dataram_wr_rdy;
    assign final_beat = beat_q == BW'(LINE_BEATS - 1);

    // Fill sequencer: latch the miss, issue the read, count beats into the RAM, report done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            set_q   <= '0;
            way_q   <= 1'b0;
            id_q    <= '0;
            beat_q  <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (txreq_vld) begin
                    addr_q <= txreq_addr;
                    set_q  <= txreq_set;
                    way_q  <= txreq_way;
                    id_q   <= txreq_id;
                    beat_q <= '0;
                    state  <= REQ;
                end
                REQ: if (mem_req_rdy) state <= DATA;
                DATA: if (beat_acc) begin
                    beat_q <= beat_q + BW'(1);
                    if (mem_rsp_last != final_beat) rsp_err <= 1'b1;
                    if (final_beat) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// tb_icache_linefill_ctrl: directed and randomized refill sequences against a transaction-level model
module tb_icache_linefill_ctrl;
    localparam int LB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        txreq_vld, txreq_rdy, txreq_way;
    logic [31:0] txreq_addr;
    logic [4:0]  txreq_set;
    logic [2:0]  txreq_id;
    logic        mem_req_vld, mem_req_rdy;
    logic [31:0] mem_req_addr;
    logic [2:0]  mem_req_id;
    logic        mem_rsp_vld, mem_rsp_rdy, mem_rsp_last;
    logic [63:0] mem_rsp_data;
    logic        dataram_wr_vld, dataram_wr_rdy, dataram_wr_way;
    logic [4:0]  dataram_wr_set;
    logic [1:0]  dataram_wr_beat;
    logic [63:0] dataram_wr_data;
    logic        linefill_done, rsp_err;
    logic [2:0]  linefill_ack_index;

    int total = 0;
    int passed = 0;
    bit err_m = 1'b0;

    icache_linefill_ctrl dut (
        .clk(clk), .rst(rst),
        .txreq_vld(txreq_vld), .txreq_rdy(txreq_rdy), .txreq_addr(txreq_addr),
        .txreq_set(txreq_set), .txreq_way(txreq_way), .txreq_id(txreq_id),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
        .dataram_wr_vld(dataram_wr_vld), .dataram_wr_rdy(dataram_wr_rdy),
        .dataram_wr_way(dataram_wr_way), .dataram_wr_set(dataram_wr_set),
        .dataram_wr_beat(dataram_wr_beat), .dataram_wr_data(dataram_wr_data),
        .linefill_done(linefill_done), .linefill_ack_index(linefill_ack_index),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // One linefill. bad: beat index whose last flag is inverted (out of range = none).
    // stall: cycles mem_req_rdy stays low. bp: random valid/ready gaps.
    // hold: keep a second request (id nid) pending during the fill. abort: beat count at which reset hits.
    task automatic fill(input logic [31:0] a, input logic [4:0] s, input logic w, input logic [2:0] id,
                        input int bad, input int stall, input bit bp, input bit hold,
                        input logic [2:0] nid, input int abort);
        int k = 0;
        int n = 0;
        logic l;
        txreq_vld = 1'b1; txreq_addr = a; txreq_set = s; txreq_way = w; txreq_id = id;
        #2;
        chk("rdy_idle", txreq_rdy, 1);
        chk("done_idle", linefill_done, 0);
        edge_step();
        if (hold) txreq_id = nid;
        else txreq_vld = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            mem_req_rdy = (i == stall);
            #2;
            chk("req_vld", mem_req_vld, 1);
            chk("req_addr", mem_req_addr, a);
            chk("req_id", mem_req_id, id);
            chk("rdy_req", txreq_rdy, 0);
            chk("wr_vld_req", dataram_wr_vld, 0);
            edge_step();
        end
        mem_req_rdy = 1'b0;
        while (k < LB && n < 200) begin
            if (k == abort) begin
                rst = 1'b1; mem_rsp_vld = 1'b1; dataram_wr_rdy = 1'b1;
                #2;
                chk("rst_rdy", txreq_rdy, 0);
                chk("rst_wr_vld", dataram_wr_vld, 0);
                chk("rst_rsp_rdy", mem_rsp_rdy, 0);
                chk("rst_done", linefill_done, 0);
                edge_step();
                rst = 1'b0; mem_rsp_vld = 1'b0; dataram_wr_rdy = 1'b0; err_m = 1'b0;
                #2;
                chk("rel_rdy", txreq_rdy, 1);
                chk("rel_done", linefill_done, 0);
                chk("rel_err", rsp_err, 0);
                return;
            end
            mem_rsp_vld    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dataram_wr_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rsp_data   = {$urandom, $urandom};
            l = (k == LB - 1) ^ (k == bad);
            mem_rsp_last = l;
            #2;
            chk("req_vld_data", mem_req_vld, 0);
            chk("wr_vld", dataram_wr_vld, mem_rsp_vld);
            chk("rsp_rdy", mem_rsp_rdy, dataram_wr_rdy);
            if (mem_rsp_vld) begin
                chk("wr_data", dataram_wr_data, mem_rsp_data);
                chk("wr_beat", dataram_wr_beat, k);
                chk("wr_set", dataram_wr_set, s);
                chk("wr_way", dataram_wr_way, w);
            end else chk("wr_data_idle", dataram_wr_data, 0);
            if (mem_rsp_vld && dataram_wr_rdy) begin
                if (l != (k == LB - 1)) err_m = 1'b1;
                k++;
            end
            edge_step();
            n++;
        end
        mem_rsp_vld = 1'b0; dataram_wr_rdy = 1'b0; mem_rsp_last = 1'b0;
        if (k < LB) chk("data_timeout", k, LB);
        #2;
        chk("done", linefill_done, 1);
        chk("ack", linefill_ack_index, id);
        chk("err", rsp_err, err_m);
        chk("rdy_done", txreq_rdy, 0);
        chk("wr_vld_done", dataram_wr_vld, 0);
        edge_step();
        #2;
        chk("done_pulse", linefill_done, 0);
        chk("ack_idle", linefill_ack_index, 0);
        chk("err_after", rsp_err, err_m);
    endtask

    initial begin
        rst = 1'b1;
        txreq_vld = 1'b0; txreq_addr = '0; txreq_set = '0; txreq_way = 1'b0; txreq_id = '0;
        mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0; mem_rsp_last = 1'b0;
        dataram_wr_rdy = 1'b0;
        edge_step();
        txreq_vld = 1'b1;
        #2;
        chk("reset_rdy", txreq_rdy, 0);
        chk("reset_req_vld", mem_req_vld, 0);
        chk("reset_wr_vld", dataram_wr_vld, 0);
        chk("reset_done", linefill_done, 0);
        chk("reset_err", rsp_err, 0);
        edge_step();
        rst = 1'b0;
        txreq_vld = 1'b0;
        #2;
        chk("post_reset_rdy", txreq_rdy, 1);
        fill(32'h1000, 5'd3, 1'b1, 3'd5, 99, 0, 1'b0, 1'b0, 3'd0, -1);
        fill(32'h2040, 5'd7, 1'b0, 3'd1, 99, 3, 1'b1, 1'b0, 3'd0, -1);
        fill(32'h3000, 5'd9, 1'b1, 3'd5, 99, 1, 1'b1, 1'b1, 3'd2, -1);
        fill(32'h3000, 5'd9, 1'b1, 3'd2, 99, 0, 1'b0, 1'b0, 3'd0, -1);
        fill(32'h4000, 5'd1, 1'b0, 3'd3, 99, 0, 1'b0, 1'b0, 3'd0, 2);
        fill(32'h5000, 5'd2, 1'b1, 3'd4, 1, 0, 1'b0, 1'b0, 3'd0, -1);
        fill(32'h5040, 5'd4, 1'b0, 3'd6, 99, 2, 1'b1, 1'b0, 3'd0, -1);
        fill(32'h6000, 5'd5, 1'b0, 3'd0, 99, 0, 1'b0, 1'b0, 3'd0, 0);
        fill(32'h7000, 5'd6, 1'b1, 3'd7, LB - 1, 0, 1'b1, 1'b0, 3'd0, -1);
        fill(32'h8000, 5'd8, 1'b1, 3'd1, 99, 0, 1'b1, 1'b0, 3'd0, 1);
        for (int i = 0; i < 12; i++)
            fill($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 1'b1, 1'b0, 3'd0, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
